// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU), radix-2 restoring, one bit/clock.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed-overflow requests in one cycle.
module div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_div_data
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_q, div_q, rem_q, quo_q, data_q;
    logic              quo_neg_q, rem_neg_q, dz_q, ovf_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, is_signed, sign_a, sign_b, in_dz, in_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   trial;
    logic              trial_ok, last_iter;
    logic [XLEN-1:0]   quo_res, rem_res, result;
    logic              unused_trial_bit;

    // Operand decode at the accept edge
    assign accept    = (state_q == StIdle) && i_start;
    assign is_signed = ~i_div_op[0];
    assign sign_a    = is_signed & i_op_a[XLEN-1];
    assign sign_b    = is_signed & i_op_b[XLEN-1];
    assign mag_a     = sign_a ? -i_op_a : i_op_a;
    assign mag_b     = sign_b ? -i_op_b : i_op_b;
    assign in_dz     = (i_op_b == '0);
    assign in_ovf    = is_signed && (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_op_b == '1);

    // One restoring step; rem_sh never exceeds 2*divisor so 33 bits plus a sign bit suffice
    assign rem_sh           = {rem_q, quo_q[XLEN-1]};
    assign trial            = {1'b0, rem_sh} - {2'b00, div_q};
    assign trial_ok         = ~trial[XLEN+1];
    assign last_iter        = (cnt_q == CNT_W'(XLEN - 1));
    assign unused_trial_bit = trial[XLEN];

    always_comb begin
        quo_res = quo_neg_q ? -quo_q : quo_q;
        rem_res = rem_neg_q ? -rem_q : rem_q;
        if (dz_q) begin
            quo_res = '1;
            rem_res = a_q;
        end else if (ovf_q) begin
            quo_res = {1'b1, {(XLEN-1){1'b0}}};
            rem_res = '0;
        end
        result = op_q[1] ? rem_res : quo_res;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
`ifdef DIV_FAST_SPECIAL_EN
                    state_d = (in_dz || in_ovf) ? StDone : StCalc;
`else
                    state_d = StCalc;
`endif
                end
            end
            StCalc:  if (last_iter) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_ready    = (state_q == StIdle);
        o_valid    = (state_q == StDone);
        o_div_data = (state_q == StDone) ? result : data_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_q      <= '0;
            a_q       <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            data_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                op_q      <= i_div_op;
                a_q       <= i_op_a;
                div_q     <= mag_b;
                rem_q     <= '0;
                quo_q     <= mag_a;
                quo_neg_q <= sign_a ^ sign_b;
                rem_neg_q <= sign_a;
                dz_q      <= in_dz;
                ovf_q     <= in_ovf;
                cnt_q     <= '0;
            end else if (state_q == StCalc) begin
                rem_q <= trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], trial_ok};
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == StDone) begin
                data_q <= result;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: results, latency, busy handling and reset abort.
module tb_div_unit;

    logic        i_clk = 1'b0;
    logic        i_reset, i_start;
    logic [1:0]  i_div_op;
    logic [31:0] i_op_a, i_op_b;
    logic        o_ready, o_valid;
    logic [31:0] o_div_data;

    int n_checks = 0;
    int n_errors = 0;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int SpecLat = 1;
`else
    localparam int SpecLat = 33;
`endif

    div_unit dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_div_op   (i_div_op),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_div_data (o_div_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one request in the current cycle (cycle 0), scramble operands during CALC,
    // then check latency, data, and the return to idle with the result held.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int cyc;
        int lat;
        lat = 0;
        check({tag, "_ready_in"}, 32'(o_ready), 32'd1);
        i_div_op = op;
        i_op_a   = a;
        i_op_b   = b;
        i_start  = 1'b1;
        step();
        i_start  = 1'b0;
        i_op_a   = ~a;
        i_op_b   = b + 32'd3;
        i_div_op = ~op;
        cyc = 1;
        while (lat == 0 && cyc <= 40) begin
            if (o_valid) lat = cyc;
            else begin
                step();
                cyc++;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, o_div_data, exp);
        step();
        check({tag, "_ready_after"}, {30'd0, o_ready, o_valid}, 32'b10);
        check({tag, "_hold"}, o_div_data, exp);
    endtask

    task automatic count_valid(input int cycles, output int n, output logic [31:0] last);
        n = 0;
        last = '0;
        for (int i = 0; i < cycles; i++) begin
            if (o_valid) begin
                n++;
                last = o_div_data;
            end
            step();
        end
    endtask

    initial begin
        int nv;
        logic [31:0] dv;
        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_div_op = 2'b00;
        i_op_a   = '0;
        i_op_b   = '0;
        step();
        step();
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", o_div_data, 32'd0);
        i_reset = 1'b0;
        step();

        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        do_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
        do_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        do_op("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
        do_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
        do_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);
        do_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, SpecLat);
        do_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, SpecLat);
        do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, SpecLat);
        do_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SpecLat);
        do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpecLat);
        do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SpecLat);

        // Second start while busy must be ignored
        i_div_op = 2'b01;
        i_op_a   = 32'hFFFF_FFFF;
        i_op_b   = 32'd1;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        for (int i = 1; i < 5; i++) step();
        i_op_b  = 32'd3;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        count_valid(45, nv, dv);
        check("busy_nvalid", 32'(nv), 32'd1);
        check("busy_data", dv, 32'hFFFF_FFFF);
        check("busy_ready", 32'(o_ready), 32'd1);

        // Reset in cycle 10 of an operation aborts it
        i_div_op = 2'b01;
        i_op_a   = 32'd100;
        i_op_b   = 32'd7;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        for (int i = 1; i < 10; i++) step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_data", o_div_data, 32'd0);
        count_valid(40, nv, dv);
        check("abort_nvalid", 32'(nv), 32'd0);
        do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // Reset and start together: reset wins, request dropped
        i_div_op = 2'b01;
        i_op_a   = 32'd50;
        i_op_b   = 32'd5;
        i_start  = 1'b1;
        i_reset  = 1'b1;
        step();
        i_start = 1'b0;
        i_reset = 1'b0;
        check("rst_start_ready", 32'(o_ready), 32'd1);
        count_valid(40, nv, dv);
        check("rst_start_nvalid", 32'(nv), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
